// File: rtl/rvr_32_pkg.sv
// Shared constants and encodings for the rvr_32 execute datapath.
// The compare helper is used by the EX operand stage.
package rvr_32_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef enum logic [2:0] {
        CMP_EQ  = 3'd0,
        CMP_NE  = 3'd1,
        CMP_LT  = 3'd4,
        CMP_GE  = 3'd5,
        CMP_LTU = 3'd6,
        CMP_GEU = 3'd7
    } cmpop_e;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } aluop_e;

    // Encodings 2 and 3 are unused and compare false.
    function automatic logic cmp_eval(input logic [2:0] op,
                                      input logic [XLEN-1:0] a,
                                      input logic [XLEN-1:0] b);
        logic res;
        case (op)
            CMP_EQ:  res = (a == b);
            CMP_NE:  res = (a != b);
            CMP_LT:  res = ($signed(a) <  $signed(b));
            CMP_GE:  res = ($signed(a) >= $signed(b));
            CMP_LTU: res = (a <  b);
            CMP_GEU: res = (a >= b);
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/rvr_32_fwd_mux.sv
// Bypass selection for one source register: MEM result beats WB result,
// and x0 always reads its register-file value.
module rvr_32_fwd_mux
    import rvr_32_pkg::*;
(
    input  logic [REG_AW-1:0] rs,
    input  logic [XLEN-1:0]   raw_data,
    input  logic              mem_wen,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [XLEN-1:0]   mem_data,
    input  logic              wb_wen,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic [XLEN-1:0]   fwd_data
);

    logic rs_nz;

    always_comb begin
        rs_nz = (rs != '0);
        fwd_data = raw_data;
        if (mem_wen && (mem_rd == rs) && rs_nz) begin
            fwd_data = mem_data;
        end else if (wb_wen && (wb_rd == rs) && rs_nz) begin
            fwd_data = wb_data;
        end
    end

endmodule

// File: rtl/rvr_32_ex_operand.sv
// ID/EX stage register with load-use stall and MEM/WB forwarding; drives
// the ALU operands, opcode and compare result.
module rvr_32_ex_operand
    import rvr_32_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [3:0]        id_aluop,
    input  logic [2:0]        id_cmpop,
    input  logic              id_src1_pc,
    input  logic              id_src2_imm,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              id_is_load,
    input  logic              id_wen,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_wen,
    input  logic [XLEN-1:0]   mem_data,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_wen,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              ex_ready,
    input  logic              flush,
    output logic              ex_valid,
    output logic [XLEN-1:0]   alu_data_in1,
    output logic [XLEN-1:0]   alu_data_in2,
    output logic [3:0]        alu_aluop,
    output logic              alu_data_cmp,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_wen,
    output logic              ex_is_load,
    output logic [XLEN-1:0]   ex_store_data
);

    logic              valid_reg;
    logic [XLEN-1:0]   pc_reg;
    logic [XLEN-1:0]   imm_reg;
    logic [REG_AW-1:0] rs1_reg;
    logic [REG_AW-1:0] rs2_reg;
    logic [REG_AW-1:0] rd_reg;
    logic [XLEN-1:0]   rs1_data_reg;
    logic [XLEN-1:0]   rs2_data_reg;
    logic [3:0]        aluop_reg;
    logic [2:0]        cmpop_reg;
    logic              src1_pc_reg;
    logic              src2_imm_reg;
    logic              wen_reg;
    logic              is_load_reg;

    logic adv;
    logic lu;

    always_comb begin
        adv = !valid_reg || ex_ready;
        lu  = id_valid && valid_reg && is_load_reg && (rd_reg != '0) &&
              ((id_use_rs1 && (id_rs1 == rd_reg)) ||
               (id_use_rs2 && (id_rs2 == rd_reg)));
        id_ready = adv && !lu && !flush;
    end

    // Bubbles and flushes only drop valid; the payload keeps its last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg    <= 1'b0;
            pc_reg       <= '0;
            imm_reg      <= '0;
            rs1_reg      <= '0;
            rs2_reg      <= '0;
            rd_reg       <= '0;
            rs1_data_reg <= '0;
            rs2_data_reg <= '0;
            aluop_reg    <= '0;
            cmpop_reg    <= '0;
            src1_pc_reg  <= 1'b0;
            src2_imm_reg <= 1'b0;
            wen_reg      <= 1'b0;
            is_load_reg  <= 1'b0;
        end else if (flush) begin
            valid_reg <= 1'b0;
        end else if (adv && lu) begin
            valid_reg <= 1'b0;
        end else if (adv) begin
            valid_reg    <= id_valid;
            pc_reg       <= id_pc;
            imm_reg      <= id_imm;
            rs1_reg      <= id_rs1;
            rs2_reg      <= id_rs2;
            rd_reg       <= id_rd;
            rs1_data_reg <= id_rs1_data;
            rs2_data_reg <= id_rs2_data;
            aluop_reg    <= id_aluop;
            cmpop_reg    <= id_cmpop;
            src1_pc_reg  <= id_src1_pc;
            src2_imm_reg <= id_src2_imm;
            wen_reg      <= id_wen;
            is_load_reg  <= id_is_load;
        end
    end

    logic [REG_AW-1:0] rs_sel   [2];
    logic [XLEN-1:0]   raw_sel  [2];
    logic [XLEN-1:0]   fwd_sel  [2];

    always_comb begin
        rs_sel[0]  = rs1_reg;
        rs_sel[1]  = rs2_reg;
        raw_sel[0] = rs1_data_reg;
        raw_sel[1] = rs2_data_reg;
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            rvr_32_fwd_mux u_fwd (
                .rs       (rs_sel[gi]),
                .raw_data (raw_sel[gi]),
                .mem_wen  (mem_wen),
                .mem_rd   (mem_rd),
                .mem_data (mem_data),
                .wb_wen   (wb_wen),
                .wb_rd    (wb_rd),
                .wb_data  (wb_data),
                .fwd_data (fwd_sel[gi])
            );
        end
    endgenerate

    always_comb begin
        alu_data_in1  = src1_pc_reg  ? pc_reg  : fwd_sel[0];
        alu_data_in2  = src2_imm_reg ? imm_reg : fwd_sel[1];
        alu_data_cmp  = cmp_eval(cmpop_reg, alu_data_in1, alu_data_in2);
        ex_store_data = fwd_sel[1];
        ex_valid      = valid_reg;
        alu_aluop     = aluop_reg;
        ex_rd         = rd_reg;
        ex_wen        = wen_reg;
        ex_is_load    = is_load_reg;
    end

endmodule

// File: doc/rvr_32_ex_operand.md
Name: rvr_32_ex_operand

Overview:
- ID/EX pipeline stage placed directly upstream of the 32-bit ALU.
- Registers decoded instruction fields on a valid/ready handshake.
- Resolves RAW hazards by forwarding from the MEM and WB stages, and detects load-use hazards by inserting a one-cycle bubble.
- Produces the ALU operands, the 4-bit aluop and the 1-bit compare result (data_cmp) the ALU consumes.

Parameters:
XLEN, 32, datapath width; only 32 is supported.
REG_AW, 5, register index width.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
id_valid  in  1  decode holds a valid instruction
id_ready  out  1  stage accepts decode instruction this cycle
id_pc  in  32  instruction PC
id_imm  in  32  sign-extended immediate
id_rs1, id_rs2, id_rd  in  5 each  register indices
id_rs1_data, id_rs2_data  in  32 each  register-file read data
id_aluop  in  4  ALU opcode, passed through
id_cmpop  in  3  compare select: 0 EQ, 1 NE, 4 LT, 5 GE, 6 LTU, 7 GEU
id_src1_pc  in  1  operand1 = pc instead of rs1
id_src2_imm  in  1  operand2 = imm instead of rs2
id_use_rs1, id_use_rs2  in  1 each  instruction reads rs1 / rs2
id_is_load, id_wen  in  1 each  load flag, register write enable
mem_rd  in  5  EX/MEM destination
mem_wen  in  1  EX/MEM writes a register
mem_data  in  32  EX/MEM ALU result
wb_rd  in  5  MEM/WB destination
wb_wen  in  1  MEM/WB writes a register
wb_data  in  32  MEM/WB writeback value
ex_ready  in  1  downstream accepts EX instruction
flush  in  1  kill the instruction in EX (branch/trap redirect)
ex_valid  out  1  EX holds a valid instruction
alu_data_in1, alu_data_in2  out  32 each  ALU operands
alu_aluop  out  4  registered aluop
alu_data_cmp  out  1  compare result for SLT/SLTU/branch
ex_rd  out  5  registered destination
ex_wen, ex_is_load  out  1 each  registered flags
ex_store_data  out  32  forwarded rs2 value for stores

Behaviour:
- Reset:
  - ex_valid = 0 and every registered field = 0.
  - Outputs follow: alu_data_in1/2 = 0, alu_data_cmp = 1 (EQ of 0,0), ex_store_data = 0.
- Advance condition: adv = !ex_valid | ex_ready.
- Load-use hazard: lu = id_valid & ex_valid & ex_is_load & ex_rd != 0 & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd)).
- id_ready = adv & !lu & !flush.
- Register update, in priority order:
  - rst: clear.
  - flush: ex_valid <= 0; decode instruction not accepted.
  - adv & lu: bubble; ex_valid <= 0.
  - adv: capture all id_* fields; ex_valid <= id_valid.
  - else: hold.
- Forwarding is combinational, evaluated in EX for each of rs1/rs2:
  - If mem_wen & mem_rd == rs & rs != 0, use mem_data.
  - Else if wb_wen & wb_rd == rs & rs != 0, use wb_data.
  - Else use the registered read data.
  - MEM has priority over WB. x0 is never forwarded.
- Operand selection:
  - alu_data_in1 = src1_pc ? pc : fwd_rs1.
  - alu_data_in2 = src2_imm ? imm : fwd_rs2.
  - ex_store_data = fwd_rs2.
- Compare:
  - alu_data_cmp is computed on (alu_data_in1, alu_data_in2).
  - LT/GE are signed 32-bit; LTU/GEU are unsigned.
  - cmpop 2 and 3 yield 0.
- Latency: one cycle from decode acceptance to EX outputs; forwarding adds no cycles.
- Simultaneous events:
  - flush with lu: flush wins.
  - flush with !ex_ready: flush still empties EX.
  - Stall (!ex_ready): all EX outputs stay stable, while forwarded values track mem/wb inputs.
- Output qualification: when ex_valid = 0, outputs are don't-care for consumers, but the registers keep their last value (no glitch-to-X).

Decomposition:
- Package rvr_32_pkg holds:
  - cmpop encodings (CMP_EQ/NE/LT/GE/LTU/GEU)
  - XLEN and REG_AW constants
  - the aluop field encodings shared with the ALU
- Sub-module rvr_32_fwd_mux: one instance per source register, taking rs, raw data and the mem/wb bypass inputs and returning the forwarded value.
- Hazard detection and the stage register stay in the top module.

Test Plan:
- Reset then id_valid=1, rs1_data=5, imm=7, src2_imm=1, aluop=0 -> next cycle ex_valid=1, alu_data_in1=5, alu_data_in2=7, alu_aluop=0.
- EX holds rs1=3; mem_wen=1, mem_rd=3, mem_data=0xAAAA; wb_wen=1, wb_rd=3, wb_data=0x5555 -> alu_data_in1=0xAAAA (MEM priority). With mem_wen=0 -> 0x5555. With rs1=0 and matching rd=0 -> raw data used.
- EX holds load with ex_rd=4; ID instruction reads rs2=4 -> id_ready=0 one cycle, then ex_valid=0 bubble; next cycle id_ready=1 and the instruction is captured.
- cmpop=LT with in1=0xFFFFFFFF, in2=1 -> alu_data_cmp=1; cmpop=LTU on the same operands -> 0; cmpop=GEU -> 1.
- ex_ready=0 for 3 cycles with id_valid=1 -> id_ready=0 and EX fields unchanged; raising ex_ready captures the pending instruction on the next edge.
- flush=1 together with id_valid=1 and lu=1 -> ex_valid=0 next cycle, id_ready=0. Asserting rst mid-stall -> all outputs return to reset values on the next edge.
